// File: rtl/writeback_unit.sv
// Write-side front end of the 32x32 register file: merges ALU results and a single
// outstanding load into one registered write port and tracks the pending load destination.
module writeback_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_reg_num_i,
  input  logic [31:0] alu_data_i,
  input  logic        ld_issue_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_reg_num_i,
  input  logic        ld_data_valid_i,
  input  logic [31:0] ld_data_i,
  output logic        wr_en_o,
  output logic [4:0]  wr_reg_num_o,
  output logic [31:0] wr_data_o,
  output logic [31:0] pending_o,
  output logic        ld_err_o
);

  // state   | meaning
  // LD_IDLE | no load outstanding, ld_issue_i accepted
  // LD_WAIT | load issued, waiting for its data
  // LD_DONE | load data sits in the output stage; bookkeeping clears at end of cycle
  typedef enum logic [1:0] {LD_IDLE, LD_WAIT, LD_DONE} ld_state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  ld_state_t   state, state_next;
  logic [4:0]  ld_dest;

  logic [4:0]  mem_reg  [FIFO_DEPTH];
  logic [31:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic alu_accept, alu_useful, ld_win, push, pop, bypass;

  assign alu_ready_o = (count < DEPTH_C);
  assign alu_accept  = alu_valid_i && alu_ready_o;
  assign alu_useful  = alu_accept && (alu_reg_num_i != 5'd0);
  // A load returning to r0 is dropped and does not claim the output stage.
  assign ld_win      = (state == LD_WAIT) && ld_data_valid_i && (ld_dest != 5'd0);
  assign pop         = !ld_win && (count != '0);
  assign bypass      = !ld_win && (count == '0) && alu_useful;
  assign push        = alu_useful && !bypass;

  always_ff @(posedge clk) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LD_IDLE: if (ld_issue_i)      state_next = LD_WAIT;
      LD_WAIT: if (ld_data_valid_i) state_next = LD_DONE;
      LD_DONE:                      state_next = LD_IDLE;
      default:                      state_next = LD_IDLE;
    endcase
  end

  always_comb begin
    ld_ready_o = (state == LD_IDLE);
    pending_o  = '0;
    if (state != LD_IDLE && ld_dest != 5'd0) pending_o[ld_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_dest  <= '0;
      ld_err_o <= 1'b0;
    end else begin
      if (state == LD_IDLE && ld_issue_i) ld_dest <= ld_reg_num_i;
      if ((ld_issue_i && state != LD_IDLE) || (ld_data_valid_i && state != LD_WAIT))
        ld_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= alu_reg_num_i;
      mem_data[wr_ptr] <= alu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_o      <= 1'b0;
      wr_reg_num_o <= '0;
      wr_data_o    <= '0;
    end else if (ld_win) begin
      wr_en_o      <= 1'b1;
      wr_reg_num_o <= ld_dest;
      wr_data_o    <= ld_data_i;
    end else if (pop) begin
      wr_en_o      <= 1'b1;
      wr_reg_num_o <= mem_reg[rd_ptr];
      wr_data_o    <= mem_data[rd_ptr];
    end else if (bypass) begin
      wr_en_o      <= 1'b1;
      wr_reg_num_o <= alu_reg_num_i;
      wr_data_o    <= alu_data_i;
    end else begin
      wr_en_o      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random checks of writeback_unit against a queue-based model of the
// write ordering and load bookkeeping.
module tb_writeback_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_reg_num_i;
  logic [31:0] alu_data_i;
  logic        ld_issue_i;
  logic        ld_ready_o;
  logic [4:0]  ld_reg_num_i;
  logic        ld_data_valid_i;
  logic [31:0] ld_data_i;
  logic        wr_en_o;
  logic [4:0]  wr_reg_num_o;
  logic [31:0] wr_data_o;
  logic [31:0] pending_o;
  logic        ld_err_o;

  writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_reg_num_i(alu_reg_num_i), .alu_data_i(alu_data_i),
    .ld_issue_i(ld_issue_i), .ld_ready_o(ld_ready_o), .ld_reg_num_i(ld_reg_num_i),
    .ld_data_valid_i(ld_data_valid_i), .ld_data_i(ld_data_i),
    .wr_en_o(wr_en_o), .wr_reg_num_o(wr_reg_num_o), .wr_data_o(wr_data_o),
    .pending_o(pending_o), .ld_err_o(ld_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  // Reference model: ALU results queue in acceptance order; every cycle without a
  // load write retires the oldest queued result.
  wr_t         q[$];
  bit          m_out, m_ret, m_err, m_wen;
  logic [4:0]  m_dest, m_num;
  logic [31:0] m_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_pending();
    return (m_out && m_dest != 5'd0) ? (32'h1 << m_dest) : 32'h0;
  endfunction

  task automatic model_update();
    bit alu_ok, ld_wr, was_out, was_ret;
    wr_t w;
    if (rst) begin
      q.delete();
      m_out = 0; m_ret = 0; m_err = 0; m_wen = 0;
      m_dest = '0; m_num = '0; m_data = '0;
      return;
    end
    alu_ok  = q.size() < DEPTH;
    ld_wr   = 0;
    was_out = m_out;
    was_ret = m_ret;
    m_wen   = 0;
    if (alu_valid_i && alu_ok && alu_reg_num_i != 5'd0)
      q.push_back('{alu_reg_num_i, alu_data_i});
    if (ld_data_valid_i) begin
      if (was_out && !was_ret) begin
        m_ret = 1;
        if (m_dest != 5'd0) begin
          ld_wr = 1; m_wen = 1; m_num = m_dest; m_data = ld_data_i;
        end
      end else m_err = 1;
    end
    if (was_out && was_ret) begin m_out = 0; m_ret = 0; end
    if (ld_issue_i) begin
      if (was_out) m_err = 1;
      else begin m_out = 1; m_ret = 0; m_dest = ld_reg_num_i; end
    end
    if (!ld_wr && q.size() > 0) begin
      w = q.pop_front();
      m_wen = 1; m_num = w.r; m_data = w.d;
    end
  endtask

  // One clock: check handshake outputs mid-cycle, advance model, check registered outputs.
  task automatic cycle();
    @(negedge clk);
    chk("alu_ready", {31'b0, alu_ready_o}, {31'b0, q.size() < DEPTH});
    chk("ld_ready", {31'b0, ld_ready_o}, {31'b0, !m_out});
    model_update();
    @(posedge clk);
    #1;
    chk("wr_en", {31'b0, wr_en_o}, {31'b0, m_wen});
    chk("wr_num", {27'b0, wr_reg_num_o}, {27'b0, m_num});
    chk("wr_data", wr_data_o, m_data);
    chk("pending", pending_o, m_pending());
    chk("ld_err", {31'b0, ld_err_o}, {31'b0, m_err});
  endtask

  task automatic idle();
    alu_valid_i = 0; alu_reg_num_i = '0; alu_data_i = '0;
    ld_issue_i = 0; ld_reg_num_i = '0; ld_data_valid_i = 0; ld_data_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] d);
    alu_valid_i = 1; alu_reg_num_i = r; alu_data_i = d;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    do_reset();
    chk("rst_wen", {31'b0, wr_en_o}, 32'd0);
    chk("rst_num", {27'b0, wr_reg_num_o}, 32'd0);
    chk("rst_data", wr_data_o, 32'd0);
    chk("rst_pend", pending_o, 32'd0);
    chk("rst_err", {31'b0, ld_err_o}, 32'd0);
    chk("rst_alu_rdy", {31'b0, alu_ready_o}, 32'd1);
    chk("rst_ld_rdy", {31'b0, ld_ready_o}, 32'd1);

    // Single ALU write, one-cycle latency
    alu(5'd5, 32'h12345678); cycle(); idle();
    chk("alu5_wen", {31'b0, wr_en_o}, 32'd1);
    chk("alu5_num", {27'b0, wr_reg_num_o}, 32'd5);
    chk("alu5_data", wr_data_o, 32'h12345678);
    cycle();
    chk("alu5_once", {31'b0, wr_en_o}, 32'd0);

    // Load to reg 7
    ld_issue_i = 1; ld_reg_num_i = 5'd7; cycle(); idle();
    chk("ld7_pend", pending_o, 32'h00000080);
    chk("ld7_rdy", {31'b0, ld_ready_o}, 32'd0);
    cycle();
    ld_data_valid_i = 1; ld_data_i = 32'hDEADBEEF; cycle(); idle();
    chk("ld7_wen", {31'b0, wr_en_o}, 32'd1);
    chk("ld7_num", {27'b0, wr_reg_num_o}, 32'd7);
    chk("ld7_data", wr_data_o, 32'hDEADBEEF);
    chk("ld7_pend_hold", pending_o, 32'h00000080);
    cycle();
    chk("ld7_pend_clr", pending_o, 32'd0);
    chk("ld7_rdy_back", {31'b0, ld_ready_o}, 32'd1);

    // Load return interleaved with an ALU stream
    ld_issue_i = 1; ld_reg_num_i = 5'd9; cycle(); idle(); cycle();
    alu(5'd1, 32'hA1); cycle();
    chk("ord_1", {27'b0, wr_reg_num_o}, 32'd1);
    alu(5'd2, 32'hA2); ld_data_valid_i = 1; ld_data_i = 32'hCAFEF00D; cycle();
    ld_data_valid_i = 0;
    chk("ord_9", {27'b0, wr_reg_num_o}, 32'd9);
    chk("ord_9_data", wr_data_o, 32'hCAFEF00D);
    alu(5'd3, 32'hA3); cycle(); idle();
    chk("ord_2", {27'b0, wr_reg_num_o}, 32'd2);
    cycle();
    chk("ord_3", {27'b0, wr_reg_num_o}, 32'd3);
    chk("ord_3_data", wr_data_o, 32'hA3);
    cycle();
    chk("ord_drain", {31'b0, wr_en_o}, 32'd0);

    // Register 0 writes are suppressed
    alu(5'd0, 32'hFFFFFFFF); cycle(); idle();
    chk("r0_alu_wen", {31'b0, wr_en_o}, 32'd0);
    ld_issue_i = 1; ld_reg_num_i = 5'd0; cycle(); idle();
    chk("r0_pend", pending_o, 32'd0);
    chk("r0_ld_rdy", {31'b0, ld_ready_o}, 32'd0);
    ld_data_valid_i = 1; ld_data_i = 32'h55AA55AA; cycle(); idle();
    chk("r0_ld_wen", {31'b0, wr_en_o}, 32'd0);
    cycle(); cycle();
    chk("r0_alu_rdy", {31'b0, alu_ready_o}, 32'd1);

    // Protocol errors
    ld_data_valid_i = 1; ld_data_i = 32'h1111; cycle(); idle();
    chk("err_spur", {31'b0, ld_err_o}, 32'd1);
    chk("err_spur_wen", {31'b0, wr_en_o}, 32'd0);
    cycle();
    chk("err_sticky", {31'b0, ld_err_o}, 32'd1);
    do_reset();
    chk("err_cleared", {31'b0, ld_err_o}, 32'd0);
    ld_issue_i = 1; ld_reg_num_i = 5'd4; cycle();
    ld_reg_num_i = 5'd6; cycle(); idle();
    chk("err_dbl", {31'b0, ld_err_o}, 32'd1);
    chk("err_dbl_pend", pending_o, 32'h00000010);
    ld_issue_i = 1; ld_reg_num_i = 5'd8; ld_data_valid_i = 1; ld_data_i = 32'h4444; cycle(); idle();
    chk("err_same_num", {27'b0, wr_reg_num_o}, 32'd4);
    cycle();
    chk("err_same_pend", pending_o, 32'd0);
    chk("err_hold", {31'b0, ld_err_o}, 32'd1);

    // Reset with a full FIFO and a load in flight
    do_reset();
    ld_issue_i = 1; ld_reg_num_i = 5'd12; alu(5'd20, 32'h20); cycle(); ld_issue_i = 0;
    ld_data_valid_i = 1; ld_data_i = 32'hC12; alu(5'd21, 32'h21); cycle(); ld_data_valid_i = 0;
    alu(5'd22, 32'h22); cycle();
    ld_issue_i = 1; ld_reg_num_i = 5'd13; alu(5'd23, 32'h23); cycle(); ld_issue_i = 0;
    ld_data_valid_i = 1; ld_data_i = 32'hC13; alu(5'd24, 32'h24); cycle(); ld_data_valid_i = 0;
    chk("full_rdy", {31'b0, alu_ready_o}, 32'd0);
    chk("full_pend", pending_o, 32'h00002000);
    rst = 1; cycle(); rst = 0; idle();
    chk("mid_rst_wen", {31'b0, wr_en_o}, 32'd0);
    chk("mid_rst_pend", pending_o, 32'd0);
    chk("mid_rst_ld_rdy", {31'b0, ld_ready_o}, 32'd1);
    chk("mid_rst_alu_rdy", {31'b0, alu_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale", {31'b0, wr_en_o}, 32'd0);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      idle();
      rst = ($urandom_range(0, 599) == 0);
      alu_valid_i   = ($urandom_range(0, 99) < 65);
      alu_reg_num_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data_i    = $urandom;
      ld_reg_num_i  = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_data_i     = $urandom;
      if (!m_out) ld_issue_i = ($urandom_range(0, 99) < 30);
      if (m_out && !m_ret) ld_data_valid_i = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 399) == 0) ld_issue_i = 1;
      if ($urandom_range(0, 399) == 0) ld_data_valid_i = 1;
      cycle();
    end
    rst = 0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
